// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC sampling controller: sample width and
// the controller state encoding.
package adc_ctrl_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Free-running sample-tick divider. Counts 0..CLK_DIV-1 and wraps, pulsing
// tick for one cycle at the terminal count. clr holds the count at zero.
module tick_div #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: cleared on request, otherwise wraps at the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A cleared divider never reports a tick, so a window being abandoned
  // cannot pick up a stray sample on its way out.
  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// ADC sampling controller: takes one ADC sample per divider tick, averages
// 2^AVG_LOG2 samples per window and presents the average as a CPU-readable
// result with valid/overrun status. Register decode lives in dmem.
//
// Result handshake: valid is set on every commit and stays high until the
// CPU reads. rd_strobe is a one-cycle pulse marking that read; on an edge
// without a commit it clears valid and overrun. A commit landing while
// valid is still set and unread raises overrun; a commit on the same edge
// as rd_strobe counts as a fresh result (valid=1, overrun=0).
module adc_sample_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_value,
  input  logic             rd_strobe,
  output logic [ADC_W-1:0] result,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WIN   = 1 << AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  state_t           state;
  state_t           state_next;
  logic             tick;
  logic             div_clr;
  logic             sample_en;
  logic             commit;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] sample_cnt;

  tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .clr  (div_clr),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: dropping enable always returns to IDLE; the last
  // sample of a window moves RUN into the one-cycle COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick && (sample_cnt == CNT_LAST)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = enable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded controls. The divider only runs while active and enabled,
  // so every RUN entry starts a full tick period from zero.
  always_comb begin
    busy      = 1'b0;
    div_clr   = 1'b0;
    sample_en = 1'b0;
    commit    = 1'b0;
    busy      = (state != IDLE);
    div_clr   = (state == IDLE) || !enable;
    sample_en = (state == RUN) && enable && tick;
    commit    = (state == COMMIT);
  end

  // Window accumulator and sample count; cleared while idle, on abandon and
  // after each commit. ACC_W holds 2^AVG_LOG2 full-scale samples without wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if ((state == IDLE) || !enable || commit) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (sample_en) begin
      acc        <= acc + ACC_W'(adc_value);
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // CPU-facing result and status. A commit still writes its result on the
  // edge where enable drops; everything is held while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (commit) begin
      result  <= acc[AVG_LOG2 +: ADC_W];
      valid   <= 1'b1;
      overrun <= rd_strobe ? 1'b0 : (overrun | valid);
    end else if (rd_strobe) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl with CLK_DIV=4, AVG_LOG2=2. A window-level
// reference model predicts each result-register update; a monitor compares
// them as the DUT presents them and flags any update nobody predicted.
module tb_adc_sample_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int AVG_LOG2 = 2;
  localparam int WIN      = 1 << AVG_LOG2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] adc_value;
  logic        rd_strobe;
  logic [11:0] result;
  logic        valid;
  logic        overrun;
  logic        busy;

  adc_sample_ctrl #(
    .CLK_DIV (CLK_DIV),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .adc_value(adc_value),
    .rd_strobe(rd_strobe),
    .result   (result),
    .valid    (valid),
    .overrun  (overrun),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          stamp;
    logic [11:0] res;
    logic        vld;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  logic [11:0] prev_result  = '0;
  logic        prev_valid   = 1'b0;
  logic        prev_overrun = 1'b0;

  // ---------------- reference model ----------------
  // Activity flag, cycles since entering the active state, captured samples
  // of the open window and a pending average for the following edge.
  bit          m_run;
  int          m_phase;
  int          m_samples[$];
  bit          m_pend;
  int          m_pend_val;
  logic [11:0] m_result;
  bit          m_valid;
  bit          m_overrun;

  task automatic model_reset();
    m_run     = 0;
    m_phase   = 0;
    m_samples.delete();
    m_pend    = 0;
    m_pend_val = 0;
    m_result  = '0;
    m_valid   = 0;
    m_overrun = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.stamp = edge_n;
    e.res   = m_result;
    e.vld   = m_valid;
    e.ovr   = m_overrun;
    exp_q.push_back(e);
  endtask

  // Advance the model across one clock edge with the inputs that edge saw.
  task automatic model_edge(input bit en, input int adc, input bit rd);
    int sum;
    if (m_pend) begin
      m_result  = m_pend_val[11:0];
      m_overrun = rd ? 1'b0 : (m_overrun | m_valid);
      m_valid   = 1'b1;
      push_exp();
    end else if (rd) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      push_exp();
    end
    m_pend = 0;
    if (!m_run) begin
      if (en) begin
        m_run   = 1;
        m_phase = 0;
      end
    end else if (!en) begin
      m_run = 0;
      m_samples.delete();
    end else begin
      if (m_phase == CLK_DIV - 1) begin
        m_samples.push_back(adc);
        if (m_samples.size() == WIN) begin
          sum = 0;
          foreach (m_samples[k]) sum += m_samples[k];
          m_pend_val = sum / WIN;
          m_pend     = 1;
          m_samples.delete();
        end
      end
      m_phase = (m_phase + 1) % CLK_DIV;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit en, input logic [11:0] adc, input bit rd);
    enable    = en;
    adc_value = adc;
    rd_strobe = rd;
    @(posedge clk);
    edge_n++;
    model_edge(en, int'(adc), rd);
    #1;
  endtask

  task automatic check_cleared(input string name);
    n_vec++;
    if (result !== 12'h000 || valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got result=%03h valid=%b overrun=%b busy=%b, required 000/0/0/0",
               name, result, valid, overrun, busy);
    end
  endtask

  // Assert reset away from the clock edge and confirm it acts immediately.
  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    enable    = 1'b0;
    rd_strobe = 1'b0;
    #1;
    check_cleared(name);
    model_reset();
    exp_q.delete();
    prev_result  = '0;
    prev_valid   = 1'b0;
    prev_overrun = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit   matched;
    exp_t e;
    matched = 0;
    while (exp_q.size() > 0 && exp_q[0].stamp < edge_n) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL stale_expect: edge %0d never checked, required %03h/%0b/%0b",
               e.stamp, e.res, e.vld, e.ovr);
    end
    if (exp_q.size() > 0 && exp_q[0].stamp == edge_n) begin
      e = exp_q.pop_front();
      matched = 1;
      n_vec++;
      if (result !== e.res || valid !== e.vld || overrun !== e.ovr) begin
        n_err++;
        $display("FAIL result_reg @edge %0d: got %03h/%b/%b, required %03h/%b/%b",
                 edge_n, result, valid, overrun, e.res, e.vld, e.ovr);
      end
    end
    if (!reset && !matched &&
        (result !== prev_result || valid !== prev_valid || overrun !== prev_overrun)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_update @edge %0d: got %03h/%b/%b, required %03h/%b/%b",
               edge_n, result, valid, overrun, prev_result, prev_valid, prev_overrun);
    end
    if (!reset) begin
      n_vec++;
      if (busy !== m_run) begin
        n_err++;
        $display("FAIL busy @edge %0d: got %b, required %b", edge_n, busy, m_run);
      end
    end
    prev_result  = result;
    prev_valid   = valid;
    prev_overrun = overrun;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    adc_value = '0;
    rd_strobe = 1'b0;
    model_reset();
    #1;
    check_cleared("reset_initial");
    @(posedge clk);
    edge_n++;
    #1;
    reset = 1'b0;

    // Held idle: nothing moves.
    repeat (3) cycle(1'b0, 12'h000, 1'b0);

    // Constant mid-scale input.
    repeat (18) cycle(1'b1, 12'h800, 1'b0);
    cycle(1'b1, 12'h800, 1'b1);

    // Realign, then feed 1,2,3,4 on the four tick edges (sum 10 -> 2).
    cycle(1'b0, 12'h000, 1'b0);
    cycle(1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 12'(i / 4 + 1), 1'b0);
    cycle(1'b1, 12'h000, 1'b0);
    cycle(1'b1, 12'h000, 1'b1);

    // Full-scale input must not wrap the accumulator.
    cycle(1'b0, 12'h000, 1'b0);
    repeat (18) cycle(1'b1, 12'hFFF, 1'b0);
    cycle(1'b1, 12'hFFF, 1'b1);

    // Two unread windows -> overrun, then a plain read clears both flags.
    repeat (34) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
    // Reads landing exactly on commit edges keep valid set, overrun clear.
    for (int i = 0; i < 40; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), m_pend);

    // Drop enable after two samples; the partial window must be discarded.
    cycle(1'b0, 12'h000, 1'b0);
    cycle(1'b1, 12'h000, 1'b0);
    repeat (8) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    cycle(1'b0, 12'h000, 1'b0);
    repeat (18) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    cycle(1'b1, 12'h000, 1'b1);

    // Reset two samples into a window; only post-reset samples count.
    cycle(1'b0, 12'h000, 1'b0);
    cycle(1'b1, 12'h000, 1'b0);
    repeat (8) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    do_reset("reset_mid_window");
    repeat (18) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    cycle(1'b1, 12'h000, 1'b1);

    // Random soak: occasional enable drops and reads.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            12'($urandom_range(0, 4095)),
            ($urandom_range(0, 9) == 0));
    end

    // Let the monitor drain, then report anything left unchecked.
    cycle(1'b0, 12'h000, 1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000, meaning clock cycles per sample tick (legal range 2..2^20).
REQ-002 The module SHALL have parameter AVG_LOG2, default 3, meaning log2 of samples averaged per window (legal range 0..6).
REQ-003 The module SHALL have port clk, input, 1, the single system clock.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port enable, input, 1, run request from the memory-mapped control register.
REQ-006 The module SHALL have port adc_value, input, 12, the live ADC channel-0 code.
REQ-007 The module SHALL have port rd_strobe, input, 1, a one-cycle pulse when the CPU reads the result register.
REQ-008 The module SHALL have port result, output, 12, the averaged sample.
REQ-009 The module SHALL have port valid, output, 1, indicating an unread result is present.
REQ-010 The module SHALL have port overrun, output, 1, indicating a result was overwritten while unread.
REQ-011 The module SHALL have port busy, output, 1, high while the state is not IDLE.

Function
REQ-012 The module SHALL use states IDLE, RUN and COMMIT.
REQ-013 IDLE SHALL go to RUN on enable=1, clearing the divider, the accumulator and the sample count.
REQ-014 In RUN and COMMIT the divider SHALL count 0..CLK_DIV-1 and wrap, asserting an internal tick for one cycle at count CLK_DIV-1.
REQ-015 On a tick in RUN, the accumulator (width 12+AVG_LOG2) SHALL add adc_value and the sample count SHALL increment.
REQ-016 On the tick that captures sample number 2^AVG_LOG2, the state SHALL go to COMMIT.
REQ-017 COMMIT SHALL last exactly one cycle; on its closing edge result SHALL load accumulator>>AVG_LOG2 (truncating), valid SHALL set, and the accumulator and count SHALL clear; the state SHALL then return to RUN.
REQ-018 Latency SHALL be: final sample captured at edge E0, result and valid updated at edge E0+1.
REQ-019 rd_strobe SHALL clear valid and overrun on the next edge when no commit occurs on that edge.
REQ-020 A commit while valid=1 with rd_strobe=0 SHALL set overrun and replace result.
REQ-021 A commit coinciding with rd_strobe=1 SHALL leave valid=1 and overrun=0, and SHALL replace result.
REQ-022 enable=0 in RUN or COMMIT SHALL force IDLE on the next edge, discarding the partial window (accumulator, count and divider cleared); a COMMIT in progress SHALL still complete its result write on that edge.
REQ-023 result, valid and overrun SHALL be retained in IDLE.
REQ-024 The accumulator SHALL never overflow: 2^AVG_LOG2 samples of 0xFFF fit its width.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, with result=0x000, valid=0, overrun=0, busy=0, and the divider, accumulator and count at 0.
REQ-026 Reset deassertion SHALL take effect synchronously with no extra wait cycles; the first RUN entry SHALL require enable=1 to be sampled on a clock edge.

Structure
REQ-027 The state enum and ADC_W=12 SHALL live in the shared package adc_ctrl_pkg.
REQ-028 The divider SHALL be the sub-module tick_div (parameter CLK_DIV; ports clk, reset, clr, tick).
REQ-029 The CPU-facing registers SHALL be decoded in dmem; this block contains no address decode.

Verification (CLK_DIV=4, AVG_LOG2=2)
REQ-030 Assert reset mid-window after 2 samples -> outputs immediately 0/0/0/0; after release with enable=1, the next result reflects only post-reset samples.
REQ-031 adc_value=0x800 constant, enable=1 -> after 4 ticks result=0x800, valid=1 at E0+1, busy=1 throughout.
REQ-032 Samples 0x001, 0x002, 0x003, 0x004 -> result=0x002 (sum 10 truncated).
REQ-033 adc_value=0xFFF constant -> result=0xFFF, with no wrap in the accumulator.
REQ-034 Two windows with no rd_strobe -> overrun=1 and result = second window; one rd_strobe -> valid=0 and overrun=0; rd_strobe on the commit cycle -> valid=1 and overrun=0.
REQ-035 Drop enable after 2 samples, then re-enable -> IDLE for one cycle, the partial window is discarded, and the next result averages 4 fresh samples.
